// File: rtl/soc_bus_decoder.sv
// soc_bus_decoder: address decode, read-data mux, wait states
// and sticky unmapped-access capture between the core and N slaves.
module soc_bus_decoder #(
    parameter int                    N_SLAVES = 4,
    parameter logic [8*N_SLAVES-1:0] SLV_BASE = 32'hE2E14000,
    parameter logic [8*N_SLAVES-1:0] SLV_MASK = 32'hFFFFF0F0,
    parameter logic [N_SLAVES-1:0]   SLV_SWAP = 4'b1100,
    parameter logic [4*N_SLAVES-1:0] SLV_WAIT = 16'h0000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [31:0]            addr_i,
    input  logic [3:0]             data_w_i,
    input  logic [31:0]            data_i,
    output logic [31:0]            data_o,
    output logic                   stall_o,
    output logic [N_SLAVES-1:0]    sel_o,
    output logic                   wr_o,
    output logic [32*N_SLAVES-1:0] slv_data_o,
    input  logic [32*N_SLAVES-1:0] slv_data_i,
    output logic                   err_o,
    output logic [31:0]            err_addr_o,
    input  logic                   err_clr_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [N_SLAVES-1:0]   dly_q, dly_d;
    logic                  err_q, err_d;
    logic [31:0]           err_addr_q, err_addr_d;
    logic [N_SLAVES-1:0]   match;
    logic [3:0]            w_sel;
    logic                  stall;
    logic                  unmapped;

    function automatic logic [31:0] bswap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    // Masked compare per slave; descending scan leaves the lowest match.
    always_comb begin
        match = '0;
        sel_o = '0;
        w_sel = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            match[k] = ((addr_i[31:24] & SLV_MASK[8*k +: 8]) ==
                        (SLV_BASE[8*k +: 8] & SLV_MASK[8*k +: 8]));
        end
        for (int k = N_SLAVES - 1; k >= 0; k--) begin
            if (match[k]) begin
                sel_o    = '0;
                sel_o[k] = 1'b1;
                w_sel    = SLV_WAIT[4*k +: 4];
            end
        end
    end

    // Read mux: current select or last-cycle select, lowest index wins.
    always_comb begin
        data_o = '0;
        for (int k = N_SLAVES - 1; k >= 0; k--) begin
            if (sel_o[k] | dly_q[k]) begin
                data_o = SLV_SWAP[k] ? bswap(slv_data_i[32*k +: 32])
                                     : slv_data_i[32*k +: 32];
            end
        end
    end

    // Per-slave write data, byte-reversed for big-endian slaves.
    always_comb begin
        slv_data_o = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            slv_data_o[32*k +: 32] = SLV_SWAP[k] ? bswap(data_i) : data_i;
        end
    end

    // Wait-state sequencing; stall is masked so reset drops it at once.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        dly_d   = sel_o;
        unique case (state_q)
            S_IDLE: begin
                if ((sel_o != '0) && (w_sel != 4'd0)) begin
                    stall   = 1'b1;
                    cnt_d   = w_sel - 4'd1;
                    state_d = (w_sel == 4'd1) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (cnt_q == 4'd1) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign stall_o = stall & ~rst_i;
    assign wr_o    = (data_w_i != 4'd0) & ~stall_o & (sel_o != '0);

    // Sticky error; a new error in the clear cycle takes precedence.
    always_comb begin
        unmapped   = (sel_o == '0) && (state_q == S_IDLE);
        err_d      = err_q;
        err_addr_d = err_addr_q;
        if (err_clr_i) begin
            err_d      = 1'b0;
            err_addr_d = '0;
        end
        if (unmapped && (!err_q || err_clr_i)) begin
            err_d      = 1'b1;
            err_addr_d = addr_i;
        end
    end

    assign err_o      = err_q;
    assign err_addr_o = err_addr_q;

    // State, counter, select-delay and error registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            dly_q      <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dly_q      <= dly_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

endmodule

// File: tb/tb_soc_bus_decoder.sv
// tb_soc_bus_decoder: directed vectors with a cycle-tagged scoreboard
// checked by an independent negedge monitor.
module tb_soc_bus_decoder;

    localparam int N = 3;

    localparam int F_SEL   = 0;
    localparam int F_DATA  = 1;
    localparam int F_STALL = 2;
    localparam int F_WR    = 3;
    localparam int F_ERR   = 4;
    localparam int F_EADDR = 5;
    localparam int F_SLV0  = 6;
    localparam int F_SLV2  = 7;

    typedef struct {
        string       name;
        int          cyc;
        int          fld;
        logic [31:0] val;
    } exp_t;

    logic            clk;
    logic            rst;
    logic [31:0]     addr;
    logic [3:0]      data_w;
    logic [31:0]     data_in;
    logic [31:0]     data_out;
    logic            stall;
    logic [N-1:0]    sel;
    logic            wr;
    logic [32*N-1:0] slv_wdata;
    logic [32*N-1:0] slv_rdata;
    logic            err;
    logic [31:0]     err_addr;
    logic            err_clr;

    int   cyc;
    int   n_pass;
    int   n_total;
    exp_t sb[$];

    soc_bus_decoder #(
        .N_SLAVES(N),
        .SLV_BASE(24'hE14000),
        .SLV_MASK(24'hFFF0F0),
        .SLV_SWAP(3'b100),
        .SLV_WAIT(12'h020)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .addr_i    (addr),
        .data_w_i  (data_w),
        .data_i    (data_in),
        .data_o    (data_out),
        .stall_o   (stall),
        .sel_o     (sel),
        .wr_o      (wr),
        .slv_data_o(slv_wdata),
        .slv_data_i(slv_rdata),
        .err_o     (err),
        .err_addr_o(err_addr),
        .err_clr_i (err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int f);
        case (f)
            F_SEL:   return {29'd0, sel};
            F_DATA:  return data_out;
            F_STALL: return {31'd0, stall};
            F_WR:    return {31'd0, wr};
            F_ERR:   return {31'd0, err};
            F_EADDR: return err_addr;
            F_SLV0:  return slv_wdata[31:0];
            F_SLV2:  return slv_wdata[95:64];
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    task automatic expect_at(input string nm, input int dc,
                             input int f, input logic [31:0] v);
        exp_t e;
        e.name = nm;
        e.cyc  = cyc + dc;
        e.fld  = f;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops every expectation due this cycle and compares.
    initial begin
        exp_t        e;
        int          n;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            n = sb.size();
            for (int i = 0; i < n; i++) begin
                e = sb.pop_front();
                if (e.cyc == cyc) begin
                    a = actual(e.fld);
                    n_total++;
                    if (a === e.val) n_pass++;
                    else $display("FAIL %s: got %h expected %h",
                                  e.name, a, e.val);
                end else if (e.cyc < cyc) begin
                    n_total++;
                    $display("FAIL %s: missed cycle %0d now %0d",
                             e.name, e.cyc, cyc);
                end else begin
                    sb.push_back(e);
                end
            end
        end
    end

    initial begin
        cyc       = 0;
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        addr      = 32'h0000_0010;
        data_w    = 4'h0;
        data_in   = '0;
        slv_rdata = '0;
        err_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset released, idle read of slave0
        rst = 1'b0;
        expect_at("rst_err", 0, F_ERR, 32'd0);
        expect_at("rst_eaddr", 0, F_EADDR, 32'd0);
        expect_at("rst_stall", 0, F_STALL, 32'd0);
        expect_at("s1_sel", 0, F_SEL, 32'd1);

        // Slave0 data arrives next cycle, held by dly_q
        step();
        addr             = 32'hE100_0004;
        slv_rdata[31:0]  = 32'h1122_3344;
        slv_rdata[95:64] = 32'hAABB_CCDD;
        expect_at("s1_dly_data", 0, F_DATA, 32'h1122_3344);
        expect_at("s1_stall", 0, F_STALL, 32'd0);
        expect_at("s2_sel", 0, F_SEL, 32'd4);

        // Slave2 swapped read and write data
        step();
        slv_rdata[31:0] = '0;
        data_in         = 32'h0102_0304;
        expect_at("s2_rdata", 0, F_DATA, 32'hDDCC_BBAA);
        expect_at("s2_wdata", 0, F_SLV2, 32'h0403_0201);
        expect_at("s0_wdata", 0, F_SLV0, 32'h0102_0304);
        expect_at("s2_nowr", 0, F_WR, 32'd0);

        step();
        data_w = 4'hF;
        expect_at("s2_wr", 0, F_WR, 32'd1);
        expect_at("s2_nostall", 0, F_STALL, 32'd0);

        // Slave1 writes, two wait states each
        step();
        addr = 32'h4000_0000;
        expect_at("w1_st0", 0, F_STALL, 32'd1);
        expect_at("w1_wr0", 0, F_WR, 32'd0);
        expect_at("w1_st1", 1, F_STALL, 32'd1);
        expect_at("w1_wr1", 1, F_WR, 32'd0);
        expect_at("w1_st2", 2, F_STALL, 32'd0);
        expect_at("w1_wr2", 2, F_WR, 32'd1);
        expect_at("w2_st0", 3, F_STALL, 32'd1);
        expect_at("w2_wr0", 3, F_WR, 32'd0);
        expect_at("w2_st1", 4, F_STALL, 32'd1);
        expect_at("w2_st2", 5, F_STALL, 32'd0);
        expect_at("w2_wr2", 5, F_WR, 32'd1);
        repeat (6) step();

        // sel on slave0 and dly on slave1: lower index wins
        addr      = 32'h0000_0010;
        data_w    = 4'h0;
        slv_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        expect_at("prio_data", 0, F_DATA, 32'h1111_1111);
        expect_at("idle_stall", 0, F_STALL, 32'd0);

        // Unmapped write
        step();
        addr   = 32'h8000_0000;
        data_w = 4'hF;
        expect_at("um_sel", 0, F_SEL, 32'd0);
        expect_at("um_nowr", 0, F_WR, 32'd0);
        expect_at("um_err0", 0, F_ERR, 32'd0);
        expect_at("um_err1", 1, F_ERR, 32'd1);
        expect_at("um_eaddr", 1, F_EADDR, 32'h8000_0000);

        step();
        addr   = 32'h9000_0000;
        data_w = 4'h0;
        expect_at("um_data0", 0, F_DATA, 32'd0);
        expect_at("um_keep", 1, F_EADDR, 32'h8000_0000);

        // Clear and new error in the same cycle
        step();
        addr    = 32'hA000_0000;
        err_clr = 1'b1;
        expect_at("clr_err", 1, F_ERR, 32'd1);
        expect_at("clr_eaddr", 1, F_EADDR, 32'hA000_0000);

        step();
        addr = 32'h0000_0010;
        expect_at("clr_only", 1, F_ERR, 32'd0);
        expect_at("clr_ea0", 1, F_EADDR, 32'd0);

        // Reset during first stall cycle
        step();
        err_clr = 1'b0;
        addr    = 32'h8000_0000;
        expect_at("pre_err", 1, F_ERR, 32'd1);

        step();
        addr = 32'h4000_0000;
        expect_at("r_st_pre", 0, F_STALL, 32'd1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        expect_at("r_st_rst", 1, F_STALL, 32'd0);
        expect_at("r_err_rst", 1, F_ERR, 32'd0);
        expect_at("r_ea_rst", 1, F_EADDR, 32'd0);

        step();
        step();
        rst = 1'b0;
        expect_at("r_st0", 0, F_STALL, 32'd1);
        expect_at("r_st1", 1, F_STALL, 32'd1);
        expect_at("r_st2", 2, F_STALL, 32'd0);
        repeat (4) step();

        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            n_total++;
            $display("FAIL %s: never checked", e.name);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
